// File: rtl/sd_block_writer_pkg.sv
// sd_block_writer_pkg: shared states, SD protocol bytes and error codes for the block writer
package sd_block_writer_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_R1, S_GAP, S_TOKEN, S_DATA, S_CRC, S_DRESP, S_BUSY, S_TAIL
    } wr_state_t;

    localparam logic [7:0] CMD24      = 8'h58;
    localparam logic [7:0] DATA_TOKEN = 8'hFE;
    localparam logic [7:0] DRESP_MASK = 8'h1F;
    localparam logic [7:0] DRESP_OK   = 8'h05;
    localparam logic [7:0] FILL       = 8'hFF;

    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_R1_TIMEOUT   = 3'd1;
    localparam logic [2:0] ERR_R1_NONZERO   = 3'd2;
    localparam logic [2:0] ERR_DATA_REJECT  = 3'd3;
    localparam logic [2:0] ERR_BUSY_TIMEOUT = 3'd4;

    localparam int R1_POLLS    = 8;
    localparam int BLOCK_BYTES = 512;

    function automatic logic data_accepted(input logic [7:0] resp);
        return (resp & DRESP_MASK) == DRESP_OK;
    endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// spi_byte_xfer: one SPI mode-0 byte exchange, MSB first, SCLK_HALF clk cycles per half-period
module spi_byte_xfer #(
    parameter int SCLK_HALF = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       done,
    output logic [7:0] rx
);

    logic        active;
    logic [6:0]  sh;
    logic [3:0]  half;
    logic [15:0] div;
    logic        edge_now;

    assign edge_now = div == 16'(SCLK_HALF - 1);

    // Divide clk into SCLK half-periods: sample on the rising edge, shift on the falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            sh     <= '0;
            half   <= '0;
            div    <= '0;
            sclk   <= 1'b0;
            mosi   <= 1'b1;
            done   <= 1'b0;
            rx     <= '0;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (start) begin
                    active <= 1'b1;
                    sh     <= tx[6:0];
                    mosi   <= tx[7];
                    div    <= '0;
                    half   <= '0;
                    sclk   <= 1'b0;
                end
            end else if (!edge_now) begin
                div <= div + 16'd1;
            end else begin
                div  <= '0;
                sclk <= ~sclk;
                half <= half + 4'd1;
                if (!sclk) begin
                    rx <= {rx[6:0], miso};
                end else if (half == 4'd15) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                    mosi   <= 1'b1;
                end else begin
                    sh   <= {sh[5:0], 1'b0};
                    mosi <= sh[6];
                end
            end
        end
    end

endmodule

// File: rtl/sd_block_writer.sv
// sd_block_writer: CMD24 single-block SDHC write over SPI; SD_WR_BUSY_TIMEOUT_EN bounds the busy poll
module sd_block_writer
    import sd_block_writer_pkg::*;
#(
    parameter int SCLK_HALF  = 2,
    parameter int BUSY_LIMIT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req,
    input  logic [31:0] block_addr,
    output logic        wr_busy,
    output logic        wr_done,
    output logic        wr_err,
    output logic [2:0]  err_code,
    output logic [8:0]  buf_addr,
    input  logic [7:0]  buf_data,
    output logic        cs,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso
);

`ifdef SD_WR_BUSY_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    wr_state_t   state;
    logic [15:0] cnt;
    logic [31:0] addr;
    logic        x_start;
    logic [7:0]  x_tx;
    logic        x_done;
    logic [7:0]  x_rx;
    logic [2:0]  err_val;

    spi_byte_xfer #(.SCLK_HALF(SCLK_HALF)) u_xfer (
        .clk   (clk),
        .rst   (rst),
        .start (x_start),
        .tx    (x_tx),
        .miso  (miso),
        .sclk  (sclk),
        .mosi  (mosi),
        .done  (x_done),
        .rx    (x_rx)
    );

    // Classify the byte just received; only meaningful while x_done is high
    always_comb begin
        err_val = (state == S_R1 && !x_rx[7] && x_rx != 8'h00) ? ERR_R1_NONZERO :
                  (state == S_R1 && x_rx[7] && cnt == 16'(R1_POLLS - 1)) ? ERR_R1_TIMEOUT :
                  (state == S_DRESP && !data_accepted(x_rx)) ? ERR_DATA_REJECT :
                  (TO_EN && state == S_BUSY && x_rx == 8'h00 && cnt == 16'(BUSY_LIMIT - 1)) ? ERR_BUSY_TIMEOUT :
                  ERR_NONE;
    end

    // Byte sequencer: each finished byte decides the next state and launches the next byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cs       <= 1'b1;
            wr_busy  <= 1'b0;
            wr_done  <= 1'b0;
            wr_err   <= 1'b0;
            err_code <= ERR_NONE;
            buf_addr <= '0;
            cnt      <= '0;
            addr     <= '0;
            x_start  <= 1'b0;
            x_tx     <= FILL;
        end else begin
            x_start <= 1'b0;
            wr_done <= 1'b0;
            if (state == S_IDLE) begin
                if (wr_req && !wr_done) begin
                    state    <= S_CMD;
                    cs       <= 1'b0;
                    addr     <= block_addr;
                    wr_busy  <= 1'b1;
                    wr_err   <= 1'b0;
                    err_code <= ERR_NONE;
                    cnt      <= '0;
                    x_tx     <= CMD24;
                    x_start  <= 1'b1;
                end
            end else if (x_done) begin
                x_start <= 1'b1;
                x_tx    <= FILL;
                cnt     <= cnt + 16'd1;
                if (err_val != ERR_NONE) begin
                    cs       <= 1'b1;
                    wr_err   <= 1'b1;
                    err_code <= err_val;
                    state    <= S_TAIL;
                end else begin
                    case (state)
                        S_CMD: begin
                            if (cnt == 16'd5) begin
                                state <= S_R1;
                                cnt   <= '0;
                            end else if (cnt < 16'd4) begin
                                x_tx <= addr[31:24];
                                addr <= {addr[23:0], 8'h00};
                            end
                        end
                        S_R1:    if (!x_rx[7]) state <= S_GAP;
                        S_GAP: begin
                            state <= S_TOKEN;
                            x_tx  <= DATA_TOKEN;
                        end
                        S_TOKEN: begin
                            state    <= S_DATA;
                            cnt      <= '0;
                            x_tx     <= buf_data;
                            buf_addr <= buf_addr + 9'd1;
                        end
                        S_DATA: begin
                            if (cnt == 16'(BLOCK_BYTES - 1)) begin
                                state <= S_CRC;
                                cnt   <= '0;
                            end else begin
                                x_tx     <= buf_data;
                                buf_addr <= buf_addr + 9'd1;
                            end
                        end
                        S_CRC:   if (cnt == 16'd1) state <= S_DRESP;
                        S_DRESP: begin
                            state <= S_BUSY;
                            cnt   <= '0;
                        end
                        S_BUSY: begin
                            if (x_rx != 8'h00) begin
                                state <= S_TAIL;
                                cs    <= 1'b1;
                            end
                        end
                        S_TAIL: begin
                            state   <= S_IDLE;
                            wr_done <= 1'b1;
                            wr_busy <= 1'b0;
                            x_start <= 1'b0;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_block_writer.sv
// tb_sd_block_writer: randomized card/SRAM model checking the MOSI byte stream and handshake of sd_block_writer
module tb_sd_block_writer;

    localparam int BL = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_req = 1'b0;
    logic [31:0] block_addr = '0;
    logic        wr_busy, wr_done, wr_err;
    logic [2:0]  err_code;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_data;
    logic        cs, sclk, mosi;
    logic        miso = 1'b1;

    logic [7:0]  mem [512];

    sd_block_writer #(.SCLK_HALF(1), .BUSY_LIMIT(BL)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .block_addr (block_addr),
        .wr_busy    (wr_busy),
        .wr_done    (wr_done),
        .wr_err     (wr_err),
        .err_code   (err_code),
        .buf_addr   (buf_addr),
        .buf_data   (buf_data),
        .cs         (cs),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso)
    );

    always #5 clk = ~clk;

    always @(posedge clk) buf_data <= mem[buf_addr];

    int errors = 0;
    int checks = 0;

    // card scenario
    int         r1d;
    logic [7:0] r1v;
    logic [7:0] dresp;
    int         busyn;

    // expected stream and observation state
    logic [8:0] exp_q [$];
    logic [2:0] exp_code;
    int         bits = 0, n = 0, nbytes = 0, done_cnt = 0;
    logic [7:0] rb = '0, cur = 8'hFF;
    logic       prev_cs = 1'b1, prev_sclk = 1'b0;
    logic [7:0] first6 [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // byte the card returns at position k of the current selection
    function automatic logic [7:0] card_byte(input int k);
        int r;
        r = 6 + r1d;
        if (k < r) return 8'hFF;
        if (k == r) return r1v;
        if (k == r + 517) return dresp;
        if (k > r + 517 && (busyn < 0 || k <= r + 517 + busyn)) return 8'h00;
        return 8'hFF;
    endfunction

    // one clk cycle: card model, byte capture, stream compare and per-cycle invariants
    task automatic step();
        logic [8:0] e;
        @(posedge clk);
        #1;
        if (rst) begin
            bits = 0; n = 0; cur = 8'hFF; prev_cs = 1'b1; prev_sclk = 1'b0;
        end else begin
            if (prev_cs && !cs) begin
                bits = 0; n = 0; nbytes = 0; cur = card_byte(0);
            end
            if (sclk && !prev_sclk) begin
                rb = {rb[6:0], mosi};
                bits++;
                if (bits == 8) begin
                    bits = 0;
                    if (nbytes < 6) first6[nbytes] = rb;
                    nbytes++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stream_extra: got byte 0x%02h cs=%0b with nothing expected", rb, cs);
                    end else begin
                        e = exp_q.pop_front();
                        chk("stream_byte", {23'd0, cs, rb}, {23'd0, e});
                    end
                    if (!cs) n++;
                    cur = cs ? 8'hFF : card_byte(n);
                end
            end
            prev_cs = cs;
            prev_sclk = sclk;
        end
        done_cnt += int'(wr_done);
        if (!cs) chk("busy_while_selected", {31'd0, wr_busy}, 1);
        if (cs && !wr_busy) chk("sclk_idle", {31'd0, sclk}, 0);
        miso = cs ? 1'b1 : cur[3'(7 - bits)];
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cs"}, {31'd0, cs}, 1);
        chk({tag, "_sclk"}, {31'd0, sclk}, 0);
        chk({tag, "_mosi"}, {31'd0, mosi}, 1);
        chk({tag, "_busy"}, {31'd0, wr_busy}, 0);
        chk({tag, "_done"}, {31'd0, wr_done}, 0);
        chk({tag, "_err"}, {31'd0, wr_err}, 0);
        chk({tag, "_code"}, {29'd0, err_code}, 0);
        chk({tag, "_baddr"}, {23'd0, buf_addr}, 0);
    endtask

    // expected MOSI stream {cs,byte} and error code from the transaction rules
    task automatic build(input logic [31:0] a);
        int np;
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h58});
        for (int i = 3; i >= 0; i--) exp_q.push_back({1'b0, a[8*i +: 8]});
        exp_q.push_back({1'b0, 8'hFF});
        np = (r1d < 8) ? r1d + 1 : 8;
        repeat (np) exp_q.push_back({1'b0, 8'hFF});
        if (r1d >= 8) exp_code = 3'd1;
        else if (r1v != 8'h00) exp_code = 3'd2;
        else begin
            exp_q.push_back({1'b0, 8'hFF});
            exp_q.push_back({1'b0, 8'hFE});
            for (int i = 0; i < 512; i++) exp_q.push_back({1'b0, mem[i]});
            repeat (3) exp_q.push_back({1'b0, 8'hFF});
            if ((dresp & 8'h1F) != 8'h05) exp_code = 3'd3;
            else if (busyn < 0) begin
`ifdef SD_WR_BUSY_TIMEOUT_EN
                repeat (BL) exp_q.push_back({1'b0, 8'hFF});
                exp_code = 3'd4;
`else
                repeat (40) exp_q.push_back({1'b0, 8'hFF});
                exp_code = 3'd0;
                return;
`endif
            end else begin
                repeat (busyn + 1) exp_q.push_back({1'b0, 8'hFF});
                exp_code = 3'd0;
            end
        end
        exp_q.push_back({1'b1, 8'hFF});
    endtask

    task automatic new_mem();
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    endtask

    task automatic accept(input logic [31:0] a, input string tag);
        build(a);
        block_addr = a;
        wr_req = 1'b1;
        step();
        wr_req = 1'b0;
        block_addr = $urandom;
        chk({tag, "_busy_after_accept"}, {31'd0, wr_busy}, 1);
        chk({tag, "_err_cleared"}, {31'd0, wr_err}, 0);
    endtask

    task automatic run_txn(input logic [31:0] a, input bit req_at_done, input string tag);
        int d0;
        d0 = done_cnt;
        accept(a, tag);
        for (int i = 0; i < 20000 && !wr_done; i++) begin
            step();
            if (i == 300 && !wr_done) begin
                block_addr = $urandom;
                wr_req = 1'b1;
                step();
                wr_req = 1'b0;
            end
        end
        chk({tag, "_done_seen"}, {31'd0, wr_done}, 1);
        chk({tag, "_err"}, {31'd0, wr_err}, {31'd0, exp_code != 3'd0});
        chk({tag, "_code"}, {29'd0, err_code}, {29'd0, exp_code});
        chk({tag, "_stream_left"}, exp_q.size(), 0);
        if (req_at_done) begin
            block_addr = $urandom;
            wr_req = 1'b1;
            step();
            wr_req = 1'b0;
        end
        repeat (4) step();
        chk({tag, "_done_once"}, done_cnt, d0 + 1);
        chk({tag, "_idle_busy"}, {31'd0, wr_busy}, 0);
        chk({tag, "_idle_cs"}, {31'd0, cs}, 1);
    endtask

    task automatic do_reset(input string tag);
        int d0;
        d0 = done_cnt;
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_reset(tag);
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        repeat (20) step();
        chk({tag, "_no_done"}, done_cnt, d0);
        chk_reset({tag, "_after"});
    endtask

    task automatic rand_ok();
        r1d = $urandom_range(0, 7);
        r1v = 8'h00;
        dresp = {3'($urandom), 5'b00101};
        busyn = $urandom_range(0, 5);
    endtask

    initial begin
        new_mem();
        step();
        step();
        chk_reset("reset");
        rst = 1'b0;
        step();
        chk_reset("reset_released");

        // nominal write: R1 on 2nd poll, accepted with E5, busy 3 bytes
        r1d = 1; r1v = 8'h00; dresp = 8'hE5; busyn = 3;
        run_txn(32'h0000_2001, 1'b0, "nominal");
        chk("nominal_nbytes", nbytes, 530);
        chk("nominal_b0", {24'd0, first6[0]}, 32'h58);
        chk("nominal_b1", {24'd0, first6[1]}, 32'h00);
        chk("nominal_b2", {24'd0, first6[2]}, 32'h00);
        chk("nominal_b3", {24'd0, first6[3]}, 32'h20);
        chk("nominal_b4", {24'd0, first6[4]}, 32'h01);
        chk("nominal_b5", {24'd0, first6[5]}, 32'hFF);

        // R1 nonzero on first poll
        r1d = 0; r1v = 8'h04;
        run_txn($urandom, 1'b0, "r1_nonzero");
        chk("r1_nonzero_nbytes", nbytes, 8);

        // card never answers R1
        r1d = 100; r1v = 8'h00;
        run_txn($urandom, 1'b0, "r1_timeout");
        chk("r1_timeout_nbytes", nbytes, 15);

        // data rejected, then a clean write with a wr_req landing on wr_done
        new_mem();
        rand_ok();
        dresp = 8'hEB;
        run_txn($urandom, 1'b0, "data_reject");
        new_mem();
        rand_ok();
        run_txn($urandom, 1'b1, "after_reject");

        // card holds busy forever
        new_mem();
        rand_ok();
        busyn = -1;
`ifdef SD_WR_BUSY_TIMEOUT_EN
        run_txn($urandom, 1'b0, "busy_timeout");
`else
        accept($urandom, "busy_hang");
        for (int i = 0; i < 20000 && exp_q.size() != 0; i++) step();
        chk("busy_hang_polled", exp_q.size(), 0);
        chk("busy_hang_busy", {31'd0, wr_busy}, 1);
        chk("busy_hang_cs", {31'd0, cs}, 0);
        do_reset("busy_hang_rst");
`endif

        // reset in the middle of data byte 100
        new_mem();
        rand_ok();
        accept($urandom, "mid_reset");
        for (int i = 0; i < 20000 && buf_addr != 9'd101; i++) step();
        chk("mid_reset_reached", {23'd0, buf_addr}, 101);
        repeat (5) step();
        do_reset("mid_reset");

        // randomized recovery writes
        for (int t = 0; t < 2; t++) begin
            new_mem();
            rand_ok();
            run_txn($urandom, 1'b0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
